mem_ctrl: RTL and testbench

Memory controller between the CPU core and the byte-wide unified RAM/IO port. It is the responder for the instruction cache's word-fetch requests and for the load/store buffer's byte, half-word and word accesses. Each request becomes a sequence of single-byte RAM cycles, assembled little-endian, and completion is signalled with a one-cycle valid pulse. Both requesters share one RAM port; the LSB has priority.

---
 rtl/mem_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: turns icache word fetches and LSB byte/half/word accesses into
// single-byte cycles on a shared synchronous RAM/IO port; LSB wins arbitration.
module mem_ctrl #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ic_ena,
    input  logic [31:0] ic_addr,
    output logic        ic_valid,
    output logic [31:0] ic_data,
    input  logic        lsb_ena,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_valid,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [1:0] {S_IDLE, S_IFETCH, S_LOAD, S_STORE} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [2:0]  r_n, w_n_nxt;
    logic [2:0]  r_iss, w_iss_nxt;
    logic [2:0]  r_cap, w_cap_nxt;
    logic        r_pend, w_pend_nxt;
    logic        r_replay, w_replay_nxt;
    logic [31:0] r_buf, w_buf_nxt;
    logic        r_ic_valid, w_ic_valid_nxt;
    logic [31:0] r_ic_data, w_ic_data_nxt;
    logic        r_lsb_valid, w_lsb_valid_nxt;
    logic [31:0] r_lsb_rdata, w_lsb_rdata_nxt;

    logic [31:0] w_mem_a;
    logic [7:0]  w_mem_dout;
    logic        w_mem_wr;
    logic        w_stall;
    logic        w_accept;
    logic        w_issue;
    logic [2:0]  w_lsb_n;
    logic [31:0] w_iss_addr;
    logic [31:0] w_cap_addr;

    assign w_lsb_n    = (lsb_len == 2'b00) ? 3'd1 : (lsb_len == 2'b01) ? 3'd2 : 3'd4;
    assign w_iss_addr = r_addr + {29'd0, r_iss};
    assign w_cap_addr = r_addr + {29'd0, r_cap};
    assign w_stall    = (r_addr[17:16] == IO_HI) && io_buffer_full;
    assign w_accept   = rdy && !r_ic_valid && !r_lsb_valid;
    assign w_issue    = (r_iss < r_n);

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_n_nxt         = r_n;
        w_iss_nxt       = r_iss;
        w_cap_nxt       = r_cap;
        w_pend_nxt      = r_pend;
        w_replay_nxt    = r_replay;
        w_buf_nxt       = r_buf;
        w_ic_valid_nxt  = r_ic_valid;
        w_ic_data_nxt   = r_ic_data;
        w_lsb_valid_nxt = r_lsb_valid;
        w_lsb_rdata_nxt = r_lsb_rdata;
        w_mem_a         = 32'd0;
        w_mem_dout      = 8'd0;
        w_mem_wr        = 1'b0;

        // Valid strobes last one active cycle; a pause freezes them with everything else.
        if (rdy) begin
            w_ic_valid_nxt  = 1'b0;
            w_lsb_valid_nxt = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept && (lsb_ena || ic_ena)) begin
                    w_iss_nxt    = 3'd0;
                    w_cap_nxt    = 3'd0;
                    w_pend_nxt   = 1'b0;
                    w_replay_nxt = 1'b0;
                    w_buf_nxt    = 32'd0;
                    if (lsb_ena) begin
                        w_state_nxt = lsb_wr ? S_STORE : S_LOAD;
                        w_addr_nxt  = lsb_addr;
                        w_wdata_nxt = lsb_wdata;
                        w_n_nxt     = w_lsb_n;
                    end else begin
                        w_state_nxt = S_IFETCH;
                        w_addr_nxt  = ic_addr;
                        w_n_nxt     = 3'd4;
                    end
                end
            end

            S_IFETCH, S_LOAD: begin
                if (r_replay)
                    w_mem_a = w_cap_addr;
                else if (w_issue)
                    w_mem_a = w_iss_addr;

                if (!rdy) begin
                    // The RAM keeps reading whatever mem_a shows, so the byte in flight is lost.
                    if (r_pend)
                        w_replay_nxt = 1'b1;
                end else if (r_replay) begin
                    w_replay_nxt = 1'b0;
                    w_pend_nxt   = 1'b1;
                end else begin
                    w_pend_nxt = w_issue;
                    if (w_issue)
                        w_iss_nxt = r_iss + 3'd1;
                    if (r_pend) begin
                        w_buf_nxt[{r_cap[1:0], 3'b000} +: 8] = mem_din;
                        w_cap_nxt = r_cap + 3'd1;
                        if (r_cap == r_n - 3'd1) begin
                            w_state_nxt = S_IDLE;
                            w_pend_nxt  = 1'b0;
                            if (r_state == S_IFETCH) begin
                                w_ic_valid_nxt = 1'b1;
                                w_ic_data_nxt  = w_buf_nxt;
                            end else begin
                                w_lsb_valid_nxt = 1'b1;
                                w_lsb_rdata_nxt = w_buf_nxt;
                            end
                        end
                    end
                end
            end

            S_STORE: begin
                w_mem_a    = w_iss_addr;
                w_mem_dout = r_wdata[{r_iss[1:0], 3'b000} +: 8];
                if (!w_stall) begin
                    w_mem_wr = rdy;
                    if (rdy) begin
                        w_iss_nxt = r_iss + 3'd1;
                        if (r_iss == r_n - 3'd1) begin
                            w_state_nxt     = S_IDLE;
                            w_lsb_valid_nxt = 1'b1;
                        end
                    end
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_n         <= 3'd0;
            r_iss       <= 3'd0;
            r_cap       <= 3'd0;
            r_pend      <= 1'b0;
            r_replay    <= 1'b0;
            r_buf       <= 32'd0;
            r_ic_valid  <= 1'b0;
            r_ic_data   <= 32'd0;
            r_lsb_valid <= 1'b0;
            r_lsb_rdata <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_n         <= w_n_nxt;
            r_iss       <= w_iss_nxt;
            r_cap       <= w_cap_nxt;
            r_pend      <= w_pend_nxt;
            r_replay    <= w_replay_nxt;
            r_buf       <= w_buf_nxt;
            r_ic_valid  <= w_ic_valid_nxt;
            r_ic_data   <= w_ic_data_nxt;
            r_lsb_valid <= w_lsb_valid_nxt;
            r_lsb_rdata <= w_lsb_rdata_nxt;
        end
    end

    assign ic_valid  = r_ic_valid;
    assign ic_data   = r_ic_data;
    assign lsb_valid = r_lsb_valid;
    assign lsb_rdata = r_lsb_rdata;
    assign mem_a     = w_mem_a;
    assign mem_dout  = w_mem_dout;
    assign mem_wr    = w_mem_wr;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed vector table, hand-written corner sequences and
// random traffic checked against a byte-array memory model.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst, rdy, ic_ena, lsb_ena, lsb_wr, io_buffer_full;
    logic        ic_valid, lsb_valid, mem_wr;
    logic [1:0]  lsb_len;
    logic [31:0] ic_addr, lsb_addr, lsb_wdata, ic_data, lsb_rdata, mem_a;
    logic [7:0]  mem_din, mem_dout;

    always #5 clk = ~clk;

    mem_ctrl #(.IO_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ic_ena(ic_ena), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_data(ic_data),
        .lsb_ena(lsb_ena), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_valid(lsb_valid), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // RAM on the DUT side (aliased on 18 address bits) and the reference image.
    logic [7:0] ram     [0:262143];
    logic [7:0] ref_mem [0:262143];

    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        mem_din <= ram[mem_a[17:0]];
    end

    typedef struct { int c; logic [31:0] a; logic [7:0] d; } wr_t;
    typedef struct {
        logic is_lsb; logic wr; logic [1:0] len; logic [31:0] addr; logic [31:0] wdata;
        int cyc; logic [31:0] data;
    } vec_t;

    int          n_vec, n_bad;
    wr_t         wlog[$];
    logic [31:0] alog [0:63];
    int          vcyc, vwho, npulse;
    logic [31:0] vdata;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic int nbytes(logic is_lsb, logic [1:0] len);
        if (!is_lsb) return 4;
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic void set_both(logic [31:0] a, logic [7:0] b);
        ram[a[17:0]]     = b;
        ref_mem[a[17:0]] = b;
    endfunction

    function automatic void model_store(logic [31:0] a, int n, logic [31:0] wd);
        logic [31:0] t;
        for (int k = 0; k < n; k++) begin
            t = a + 32'(k);
            ref_mem[t[17:0]] = wd[8*k +: 8];
        end
    endfunction

    function automatic logic [31:0] ref_word(logic [31:0] a, int n);
        logic [31:0] t, d;
        d = 32'd0;
        for (int k = 0; k < n; k++) begin
            t = a + 32'(k);
            d[8*k +: 8] = ref_mem[t[17:0]];
        end
        return d;
    endfunction

    // One transaction from cycle 0 (request sampled at its end) until the cycle after valid.
    task automatic run(input logic is_lsb, input logic wr, input logic [1:0] len,
                       input logic [31:0] addr, input logic [31:0] wdata, input int maxc,
                       input logic [63:0] rdy_lo, input logic [63:0] full_hi, input int rst_at);
        wr_t w;
        wlog.delete();
        vcyc = -1; vwho = 0; npulse = 0;
        for (int i = 0; i < 64; i++) alog[i] = 32'd0;
        for (int c = 0; c <= maxc; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                if (is_lsb) begin
                    lsb_ena = 1'b1; lsb_wr = wr; lsb_len = len; lsb_addr = addr; lsb_wdata = wdata;
                end else begin
                    ic_ena = 1'b1; ic_addr = addr;
                end
            end
            if (vcyc >= 0 || c >= rst_at) begin ic_ena = 1'b0; lsb_ena = 1'b0; end
            rdy = !rdy_lo[c];
            io_buffer_full = full_hi[c];
            rst = (c == rst_at);
            @(negedge clk);
            alog[c] = mem_a;
            if (mem_wr) begin w.c = c; w.a = mem_a; w.d = mem_dout; wlog.push_back(w); end
            if (ic_valid || lsb_valid) begin
                npulse++;
                if (vcyc < 0) begin
                    vcyc  = c;
                    vwho  = (lsb_valid ? 2 : 0) + (ic_valid ? 1 : 0);
                    vdata = lsb_valid ? lsb_rdata : ic_data;
                end
            end
            if (vcyc >= 0 && c > vcyc) break;
        end
        rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    endtask

    task automatic model_check(input logic is_lsb, input logic wr, input logic [1:0] len,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [63:0] fh, input int t);
        int n, c, k;
        logic [31:0] ea;
        n = nbytes(is_lsb, len);
        chk($sformatf("rnd%0d pulses", t), npulse, 1);
        if (is_lsb && wr) begin
            chk($sformatf("rnd%0d write count", t), wlog.size(), n);
            c = 1; k = 0;
            while (k < n) begin
                if (a[17:16] == 2'b11 && fh[c]) c++;
                else begin
                    ea = a + 32'(k);
                    if (k < wlog.size()) begin
                        chk($sformatf("rnd%0d wr%0d cycle", t, k), wlog[k].c, c);
                        chk($sformatf("rnd%0d wr%0d addr", t, k), wlog[k].a, ea);
                        chk($sformatf("rnd%0d wr%0d byte", t, k), {24'd0, wlog[k].d}, {24'd0, wd[8*k +: 8]});
                    end
                    k++; c++;
                end
            end
            chk($sformatf("rnd%0d store valid cycle", t), vcyc, c);
            chk($sformatf("rnd%0d store requester", t), vwho, 2);
            model_store(a, n, wd);
        end else begin
            chk($sformatf("rnd%0d read valid cycle", t), vcyc, n + 2);
            chk($sformatf("rnd%0d read requester", t), vwho, is_lsb ? 2 : 1);
            chk($sformatf("rnd%0d read data", t), vdata, ref_word(a, n));
            chk($sformatf("rnd%0d read no writes", t), wlog.size(), 0);
            for (int j = 0; j < n; j++)
                chk($sformatf("rnd%0d issue%0d", t, j), alog[j+1], a + 32'(j));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        tv [0:9];
        logic [31:0] r32, a, wd;
        logic [63:0] fh;
        logic [1:0]  len;
        logic        is_lsb, wr;
        int          kind, tl, ti, both, k, last, nmis;
        logic [31:0] dl, di;

        n_vec = 0; n_bad = 0;
        rst = 1'b1; rdy = 1'b1; ic_ena = 1'b0; lsb_ena = 1'b0; lsb_wr = 1'b0; lsb_len = 2'b00;
        ic_addr = 32'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0; io_buffer_full = 1'b0;
        for (int i = 0; i < 262144; i++) begin
            r32 = $urandom;
            ram[i] = r32[7:0];
            ref_mem[i] = r32[7:0];
        end
        set_both(32'h100, 8'h13); set_both(32'h101, 8'h05);
        set_both(32'h102, 8'h10); set_both(32'h103, 8'h00);
        set_both(32'h1001, 8'hAB);
        set_both(32'h3FFFE, 8'h11); set_both(32'h0, 8'h22); set_both(32'h1, 8'h33);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ic_valid", {31'd0, ic_valid}, 32'd0);
        chk("reset lsb_valid", {31'd0, lsb_valid}, 32'd0);
        chk("reset mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("reset mem_a", mem_a, 32'd0);
        chk("reset mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("reset ic_data", ic_data, 32'd0);
        chk("reset lsb_rdata", lsb_rdata, 32'd0);
        rst = 1'b0;

        tv[0] = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         6, 32'h0010_0513};
        tv[1] = '{1'b1, 1'b0, 2'd0, 32'h0000_1001, 32'h0,         3, 32'h0000_00AB};
        tv[2] = '{1'b1, 1'b1, 2'd1, 32'h0000_0040, 32'h1234_BEEF, 3, 32'h0};
        tv[3] = '{1'b1, 1'b0, 2'd1, 32'h0000_0040, 32'h0,         4, 32'h0000_BEEF};
        tv[4] = '{1'b1, 1'b1, 2'd2, 32'h0000_0041, 32'hDEAD_BEEF, 5, 32'h0};
        tv[5] = '{1'b1, 1'b0, 2'd2, 32'h0000_0040, 32'h0,         6, 32'hADBE_EFEF};
        tv[6] = '{1'b1, 1'b0, 2'd0, 32'h0000_0044, 32'h0,         3, 32'h0000_00DE};
        tv[7] = '{1'b1, 1'b0, 2'd3, 32'h0000_0041, 32'h0,         6, 32'hDEAD_BEEF};
        tv[8] = '{1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_005A, 2, 32'h0};
        tv[9] = '{1'b0, 1'b0, 2'd0, 32'hFFFF_FFFE, 32'h0,         6, 32'h3322_5A11};

        for (int i = 0; i < 10; i++) begin
            run(tv[i].is_lsb, tv[i].wr, tv[i].len, tv[i].addr, tv[i].wdata, 20, 64'd0, 64'd0, 999);
            chk($sformatf("tv%0d valid cycle", i), vcyc, tv[i].cyc);
            chk($sformatf("tv%0d pulses", i), npulse, 1);
            chk($sformatf("tv%0d requester", i), vwho, tv[i].is_lsb ? 2 : 1);
            if (tv[i].is_lsb && tv[i].wr) begin
                chk($sformatf("tv%0d write count", i), wlog.size(), nbytes(1'b1, tv[i].len));
                model_store(tv[i].addr, nbytes(1'b1, tv[i].len), tv[i].wdata);
            end else begin
                chk($sformatf("tv%0d data", i), vdata, tv[i].data);
                for (int j = 0; j < nbytes(tv[i].is_lsb, tv[i].len); j++)
                    chk($sformatf("tv%0d issue%0d", i, j), alog[j+1], tv[i].addr + 32'(j));
            end
        end

        // Block refill: requester bumps its address on every valid and keeps ena high.
        @(posedge clk); #1;
        ic_addr = 32'h200; ic_ena = 1'b1;
        k = 0; last = -1;
        for (int t = 0; t < 60 && k < 4; t++) begin
            @(negedge clk);
            if (ic_valid) begin
                chk($sformatf("refill word%0d", k), ic_data, ref_word(32'h200 + 32'(4*k), 4));
                if (k == 0) chk("refill first valid", t, 6);
                else chk($sformatf("refill gap%0d", k), t - last, 7);
                last = t;
                k++;
            end
            @(posedge clk); #1;
            if (last == t) begin
                if (k == 4) ic_ena = 1'b0;
                else ic_addr = ic_addr + 32'd4;
            end
        end
        ic_ena = 1'b0;
        chk("refill pulse count", k, 4);
        @(negedge clk);

        // Simultaneous LSB and icache requests.
        @(posedge clk); #1;
        lsb_ena = 1'b1; lsb_wr = 1'b0; lsb_len = 2'b00; lsb_addr = 32'h1001;
        ic_ena = 1'b1; ic_addr = 32'h100;
        tl = -1; ti = -1; both = 0; dl = 32'd0; di = 32'd0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (tl >= 0) lsb_ena = 1'b0;
            if (ti >= 0) ic_ena = 1'b0;
            @(negedge clk);
            if (lsb_valid && ic_valid) both++;
            if (lsb_valid && tl < 0) begin tl = c; dl = lsb_rdata; end
            if (ic_valid && ti < 0) begin ti = c; di = ic_data; end
        end
        lsb_ena = 1'b0; ic_ena = 1'b0;
        chk("conflict lsb valid cycle", tl, 3);
        chk("conflict lsb data", dl, 32'h0000_00AB);
        chk("conflict ic valid cycle", ti, 10);
        chk("conflict ic data", di, 32'h0010_0513);
        chk("conflict valids overlap", both, 0);

        // IO store held off by a full write FIFO for cycles 1..3.
        run(1'b1, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0077, 20, 64'd0, 64'h0E, 999);
        chk("io store write count", wlog.size(), 1);
        if (wlog.size() > 0) begin
            chk("io store write cycle", wlog[0].c, 4);
            chk("io store write addr", wlog[0].a, 32'h0003_0000);
            chk("io store write byte", {24'd0, wlog[0].d}, 32'h77);
        end
        chk("io store valid cycle", vcyc, 5);
        chk("io store pulses", npulse, 1);
        model_store(32'h0003_0000, 1, 32'h77);

        // Outside the IO region a full FIFO does not stall.
        run(1'b1, 1'b1, 2'd0, 32'h0002_0000, 32'h0000_0066, 20, 64'd0, 64'h0E, 999);
        chk("ram store valid cycle", vcyc, 2);
        chk("ram store write count", wlog.size(), 1);
        model_store(32'h0002_0000, 1, 32'h66);

        // Pause of two cycles mid fetch: 2 + 1 replay cycle late.
        run(1'b0, 1'b0, 2'd0, 32'h100, 32'h0, 20, 64'h18, 64'd0, 999);
        chk("pause fetch valid cycle", vcyc, 9);
        chk("pause fetch data", vdata, 32'h0010_0513);
        chk("pause fetch pulses", npulse, 1);

        // Pause during the only capture cycle of a byte load.
        run(1'b1, 1'b0, 2'd0, 32'h1001, 32'h0, 20, 64'h04, 64'd0, 999);
        chk("pause byte valid cycle", vcyc, 5);
        chk("pause byte data", vdata, 32'h0000_00AB);

        // Pause in the issue cycle: nothing in flight, no replay.
        run(1'b1, 1'b0, 2'd0, 32'h1001, 32'h0, 20, 64'h02, 64'd0, 999);
        chk("pause issue valid cycle", vcyc, 4);
        chk("pause issue data", vdata, 32'h0000_00AB);

        // Pause mid store: no write while paused.
        run(1'b1, 1'b1, 2'd2, 32'h80, 32'h0403_0201, 20, 64'h04, 64'd0, 999);
        chk("pause store write count", wlog.size(), 4);
        if (wlog.size() > 1) chk("pause store 2nd write cycle", wlog[1].c, 3);
        chk("pause store valid cycle", vcyc, 6);
        model_store(32'h80, 4, 32'h0403_0201);

        // Reset in store cycle 2 abandons the store.
        run(1'b1, 1'b1, 2'd2, 32'h90, 32'hCAFE_F00D, 10, 64'd0, 64'd0, 2);
        chk("reset store write count", wlog.size(), 2);
        chk("reset store pulses", npulse, 0);
        chk("reset store mem_a idle", alog[3], 32'd0);
        model_store(32'h90, 2, 32'hCAFE_F00D);

        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 3);
            r32 = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC + {30'd0, r32[1:0]};
            else if (kind == 3) a = {14'd0, 2'b11, r32[15:0]};
            else a = {14'd0, r32[17:0]};
            is_lsb = (kind != 0);
            wr = (kind >= 2);
            r32 = $urandom;
            len = r32[1:0];
            wd = $urandom;
            r32 = $urandom;
            fh = {48'd0, r32[15:0]};
            run(is_lsb, wr, len, a, wd, 40, 64'd0, fh, 999);
            model_check(is_lsb, wr, len, a, wd, fh, t);
        end

        nmis = 0;
        for (int i = 0; i < 262144; i++)
            if (ram[i] !== ref_mem[i]) nmis++;
        chk("final memory image", nmis, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
